evm_ballot_controller: RTL and testbench

- Upstream front-end for the EVM tally/7-segment block.
- Conditions the four raw voter buttons: 2-FF synchronise, debounce, rising-edge detect.
- Enforces one vote per officer-issued ballot and rejects ambiguous multi-button presses.
- Emits single-cycle, mutually exclusive P1/P2/P3/NOTA vote pulses that drive the tally block's P1, P2, P3, NOTA inputs directly, on the same CLK.

---
 rtl/evm_ballot_controller_if.sv | 30 +++
 rtl/evm_ballot_controller.sv | 137 +++++++++++++
 tb/tb_evm_ballot_controller.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evm_ballot_controller_if.sv
// rtl/evm_ballot_controller_if.sv - voter/officer inputs and vote/status outputs of the ballot controller
//
// Purpose: bundles the button, ballot-issue and tally-facing signals.
// master: drives buttons and BALLOT_EN, observes vote pulses and status.
// slave : the ballot controller itself.
interface evm_ballot_controller_if;
    logic       P1_BTN;
    logic       P2_BTN;
    logic       P3_BTN;
    logic       NOTA_BTN;
    logic       BALLOT_EN;
    logic       P1;
    logic       P2;
    logic       P3;
    logic       NOTA;
    logic       READY;
    logic       MULTI_ERR;
    logic       TIMEOUT;
    logic [7:0] BALLOTS_CAST;

    modport master (
        output P1_BTN, P2_BTN, P3_BTN, NOTA_BTN, BALLOT_EN,
        input  P1, P2, P3, NOTA, READY, MULTI_ERR, TIMEOUT, BALLOTS_CAST
    );

    modport slave (
        input  P1_BTN, P2_BTN, P3_BTN, NOTA_BTN, BALLOT_EN,
        output P1, P2, P3, NOTA, READY, MULTI_ERR, TIMEOUT, BALLOTS_CAST
    );
endinterface

// File: rtl/evm_ballot_controller.sv
// rtl/evm_ballot_controller.sv - button conditioning and one-vote-per-ballot FSM for the EVM tally
//
// Purpose: synchronises and debounces the four voter buttons, accepts exactly one
// unambiguous press per officer-issued ballot and emits one-cycle vote pulses.
// Ports:
//   CLK     - system clock shared with the tally block
//   CLEAR_N - asynchronous active-low reset
//   bus     - slave side of evm_ballot_controller_if (buttons, BALLOT_EN,
//             P1/P2/P3/NOTA pulses, READY, MULTI_ERR, TIMEOUT, BALLOTS_CAST)
module evm_ballot_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                     CLK,
    input  logic                     CLEAR_N,
    evm_ballot_controller_if.slave   bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAST    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_REJECT  = 3'd4;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    // Bit order everywhere: 0 = P1, 1 = P2, 2 = P3, 3 = NOTA.
    logic [3:0]  w_raw;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_deb;
    logic [3:0]  r_deb_q;
    logic [15:0] r_db_cnt [4];
    logic        r_ben_q;
    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [1:0]  r_vote;
    logic [23:0] r_to_cnt;
    logic [7:0]  r_cast_cnt;

    logic [3:0]  w_press;
    logic [2:0]  w_nheld;
    logic        w_held;
    logic        w_ben_edge;
    logic        w_multi_press;
    logic        w_single_press;
    logic        w_expire;

    assign w_raw          = {bus.NOTA_BTN, bus.P3_BTN, bus.P2_BTN, bus.P1_BTN};
    assign w_press        = r_deb & ~r_deb_q;
    assign w_nheld        = 3'($countones(r_deb));
    assign w_held         = |r_deb;
    assign w_ben_edge     = bus.BALLOT_EN & ~r_ben_q;
    // A new edge while another button is already down is ambiguous, so it is
    // rejected even though only one bit has an edge this cycle.
    assign w_multi_press  = (|w_press) && (w_nheld >= 3'd2);
    assign w_single_press = (|w_press) && (w_nheld == 3'd1);
    assign w_expire       = (r_to_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            r_ben_q <= 1'b0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            r_ben_q <= bus.BALLOT_EN;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_ben_edge) w_next = S_ARMED;
            S_ARMED: begin
                if (w_multi_press)       w_next = S_REJECT;
                else if (w_single_press) w_next = S_CAST;
                else if (w_expire)       w_next = S_IDLE;
            end
            S_CAST:    w_next = S_RELEASE;
            S_RELEASE: if (!w_held) w_next = S_IDLE;
            // Expiry wins over the release wait.
            S_REJECT: begin
                if (w_expire)     w_next = S_IDLE;
                else if (!w_held) w_next = S_ARMED;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_state    <= S_IDLE;
            r_vote     <= 2'd0;
            r_to_cnt   <= '0;
            r_cast_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ARMED && !w_multi_press && w_single_press)
                r_vote <= {w_press[3] | w_press[2], w_press[3] | w_press[1]};
            // The timeout spans ARMED and REJECT together; only a fresh ballot restarts it.
            if (r_state == S_IDLE && w_ben_edge)
                r_to_cnt <= '0;
            else if (r_state == S_ARMED || r_state == S_REJECT)
                r_to_cnt <= r_to_cnt + 24'd1;
            if (r_state == S_CAST)
                r_cast_cnt <= r_cast_cnt + 8'd1;
        end
    end

    // Outputs decode registered state only, so CLEAR_N drops them immediately.
    assign bus.P1           = (r_state == S_CAST) && (r_vote == 2'd0);
    assign bus.P2           = (r_state == S_CAST) && (r_vote == 2'd1);
    assign bus.P3           = (r_state == S_CAST) && (r_vote == 2'd2);
    assign bus.NOTA         = (r_state == S_CAST) && (r_vote == 2'd3);
    assign bus.READY        = (r_state == S_ARMED);
    assign bus.MULTI_ERR    = (r_state == S_ARMED) && w_multi_press;
    assign bus.TIMEOUT      = w_expire &&
                              (((r_state == S_ARMED) && !w_multi_press && !w_single_press) ||
                               (r_state == S_REJECT));
    assign bus.BALLOTS_CAST = r_cast_cnt;
endmodule

// File: tb/tb_evm_ballot_controller.sv
// tb/tb_evm_ballot_controller.sv - randomized and directed bench for evm_ballot_controller against a reference model
module tb_evm_ballot_controller;
    localparam int DB   = 4;
    localparam int TO_A = 1000;
    localparam int TO_B = 10;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_CAST    = 2;
    localparam int M_RELEASE = 3;
    localparam int M_REJECT  = 4;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] btn;
    logic       ben;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    evm_ballot_controller_if if_a ();
    evm_ballot_controller_if if_b ();

    assign if_a.P1_BTN = btn[0];  assign if_b.P1_BTN = btn[0];
    assign if_a.P2_BTN = btn[1];  assign if_b.P2_BTN = btn[1];
    assign if_a.P3_BTN = btn[2];  assign if_b.P3_BTN = btn[2];
    assign if_a.NOTA_BTN = btn[3]; assign if_b.NOTA_BTN = btn[3];
    assign if_a.BALLOT_EN = ben;  assign if_b.BALLOT_EN = ben;

    evm_ballot_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .CLK(clk), .CLEAR_N(clear_n), .bus(if_a.slave));
    evm_ballot_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .CLK(clk), .CLEAR_N(clear_n), .bus(if_b.slave));

    // Reference model: one record per DUT, stepped once per clock edge.
    typedef struct {
        int       ph;
        int       vote;
        int       tcnt;
        int       casts;
        bit       bq;
        bit [3:0] s1;
        bit [3:0] s2;
        bit [3:0] deb;
        bit [3:0] debq;
        int       run0;
        int       run1;
        int       run2;
        int       run3;
    } model_t;

    model_t m [2];
    int     m_to [2] = '{TO_A, TO_B};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset(input int k);
        m[k].ph = M_IDLE; m[k].vote = 0; m[k].tcnt = 0; m[k].casts = 0; m[k].bq = 0;
        m[k].s1 = 0; m[k].s2 = 0; m[k].deb = 0; m[k].debq = 0;
        m[k].run0 = 0; m[k].run1 = 0; m[k].run2 = 0; m[k].run3 = 0;
    endfunction

    // A button's debounced level flips once its synchronised level has disagreed
    // for DB consecutive samples; returns the updated run length.
    function automatic int deb_run(input bit s, inout bit d, input int run);
        if (s == d) return 0;
        if (run + 1 >= DB) begin
            d = ~d;
            return 0;
        end
        return run + 1;
    endfunction

    function automatic void m_step(input int k, input bit [3:0] raw, input bit be);
        model_t   o  = m[k];
        model_t   n  = m[k];
        bit [3:0] pr = o.deb & ~o.debq;
        int       np = $countones(pr);
        int       nh = $countones(o.deb);
        bit       te = (o.tcnt == m_to[k] - 1);
        bit       d;
        case (o.ph)
            M_IDLE:    if (be && !o.bq) begin n.ph = M_ARMED; n.tcnt = 0; end
            M_ARMED: begin
                n.tcnt = o.tcnt + 1;
                if (np > 0 && nh >= 2) n.ph = M_REJECT;
                else if (np == 1 && nh == 1) begin
                    n.ph = M_CAST;
                    for (int i = 0; i < 4; i++) if (pr[i]) n.vote = i;
                end else if (te) n.ph = M_IDLE;
            end
            M_CAST:    begin n.casts = (o.casts + 1) % 256; n.ph = M_RELEASE; end
            M_RELEASE: if (nh == 0) n.ph = M_IDLE;
            default: begin
                n.tcnt = o.tcnt + 1;
                if (te) n.ph = M_IDLE;
                else if (nh == 0) n.ph = M_ARMED;
            end
        endcase
        d = o.deb[0]; n.run0 = deb_run(o.s2[0], d, o.run0); n.deb[0] = d;
        d = o.deb[1]; n.run1 = deb_run(o.s2[1], d, o.run1); n.deb[1] = d;
        d = o.deb[2]; n.run2 = deb_run(o.s2[2], d, o.run2); n.deb[2] = d;
        d = o.deb[3]; n.run3 = deb_run(o.s2[3], d, o.run3); n.deb[3] = d;
        n.debq = o.deb;
        n.s2   = o.s1;
        n.s1   = raw;
        n.bq   = be;
        m[k]   = n;
    endfunction

    // Expected {P1,P2,P3,NOTA,READY,MULTI_ERR,TIMEOUT}.
    function automatic logic [6:0] m_out(input int k);
        logic [6:0] r  = '0;
        bit [3:0]   pr = m[k].deb & ~m[k].debq;
        int         np = $countones(pr);
        int         nh = $countones(m[k].deb);
        bit         multi  = (np > 0 && nh >= 2);
        bit         single = (np == 1 && nh == 1);
        bit         te = (m[k].tcnt == m_to[k] - 1);
        if (m[k].ph == M_CAST) r[6 - m[k].vote] = 1'b1;
        r[2] = (m[k].ph == M_ARMED);
        r[1] = (m[k].ph == M_ARMED) && multi;
        r[0] = te && (((m[k].ph == M_ARMED) && !multi && !single) || (m[k].ph == M_REJECT));
        return r;
    endfunction

    function automatic logic [6:0] get_out(input int k);
        if (k == 0)
            return {if_a.P1, if_a.P2, if_a.P3, if_a.NOTA, if_a.READY, if_a.MULTI_ERR, if_a.TIMEOUT};
        return {if_b.P1, if_b.P2, if_b.P3, if_b.NOTA, if_b.READY, if_b.MULTI_ERR, if_b.TIMEOUT};
    endfunction

    function automatic logic [7:0] get_cnt(input int k);
        return (k == 0) ? if_a.BALLOTS_CAST : if_b.BALLOTS_CAST;
    endfunction

    task automatic tick();
        logic [6:0] g;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!clear_n) m_reset(k);
            else m_step(k, btn, ben);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g = get_out(k);
            check($sformatf("outs%0d", k), 32'(g), 32'(m_out(k)));
            check($sformatf("count%0d", k), 32'(get_cnt(k)), 32'(m[k].casts));
            check($sformatf("onehot%0d", k), 32'($countones(g[6:3]) <= 1), 32'd1);
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0; btn = '0; ben = 1'b0;
        tick(); tick();
        clear_n = 1'b1;
        tick();
    endtask

    task automatic issue();
        ben = 1'b1; tick();
        ben = 1'b0; tick();
    endtask

    // Ticks until the selected output bit of DUT k is high; n = ticks taken or -1.
    task automatic wait_bit(input int k, input int bpos, input int limit, output int n);
        logic [6:0] g;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            g = get_out(k);
            if (g[bpos]) begin n = i; break; end
        end
    endtask

    // Counts cycles within the window where the selected output bit of DUT k is high.
    task automatic count_bit(input int k, input int bpos, input int len, output int n);
        logic [6:0] g;
        n = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            g = get_out(k);
            if (g[bpos]) n++;
        end
    endtask

    initial begin
        int n, c, hold;
        logic [6:0] g;

        clear_n = 1'b0; btn = '0; ben = 1'b0;
        tick(); tick();
        check("rst_outs_a", 32'(get_out(0)), 32'd0);
        check("rst_outs_b", 32'(get_out(1)), 32'd0);
        check("rst_count_a", 32'(get_cnt(0)), 32'd0);
        clear_n = 1'b1;
        tick();

        // Clean P1 vote, then RELEASE ignores a ballot until the button is let go.
        issue();
        check("t1_ready", 32'(if_a.READY), 32'd1);
        btn = 4'b0001;
        wait_bit(0, 6, 30, n);
        check("t1_latency", 32'(n), 32'd7);
        tick();
        check("t1_p1_width", 32'(if_a.P1), 32'd0);
        check("t1_count", 32'(get_cnt(0)), 32'd1);
        repeat (12) tick();
        issue();
        check("t1_release_hold", 32'(if_a.READY), 32'd0);
        btn = 4'b0000;
        repeat (8) tick();
        issue();
        check("t1_rearm", 32'(if_a.READY), 32'd1);

        // Presses with no ballot are ignored.
        do_reset();
        c = 0;
        for (int r = 0; r < 3; r++) begin
            btn = 4'b0010; count_bit(0, 5, 8, n); c += n;
            btn = 4'b0000; count_bit(0, 5, 8, n); c += n;
        end
        check("t2_p2_pulses", 32'(c), 32'd0);
        check("t2_count", 32'(get_cnt(0)), 32'd0);

        // Bouncing P3: timed from the final stable rise, single pulse.
        do_reset();
        issue();
        btn = 4'b0100; tick();
        btn = 4'b0000; tick();
        btn = 4'b0100; tick();
        btn = 4'b0000; tick();
        btn = 4'b0100;
        wait_bit(0, 4, 30, n);
        check("t3_latency", 32'(n), 32'd7);
        count_bit(0, 4, 15, c);
        check("t3_extra", 32'(c), 32'd0);
        btn = 4'b0000; repeat (8) tick();

        // Simultaneous P1+NOTA rejected, then a lone NOTA accepted.
        do_reset();
        issue();
        btn = 4'b1001;
        count_bit(0, 1, 12, n);
        check("t4_multi_err", 32'(n), 32'd1);
        check("t4_no_vote", 32'(get_cnt(0)), 32'd0);
        btn = 4'b0000; repeat (8) tick();
        check("t4_rearmed", 32'(if_a.READY), 32'd1);
        btn = 4'b1000;
        wait_bit(0, 3, 30, n);
        check("t4_nota_latency", 32'(n), 32'd7);
        tick();
        check("t4_count", 32'(get_cnt(0)), 32'd1);
        btn = 4'b0000; repeat (8) tick();

        // Timeout on the TIMEOUT_CYCLES=10 instance.
        do_reset();
        ben = 1'b1; tick(); ben = 1'b0;
        c = 0; n = -1;
        for (int i = 0; i < 20; i++) begin
            if (if_b.READY) c++;
            if (if_b.TIMEOUT) begin n = c; break; end
            tick();
        end
        check("t5_timeout_cycle", 32'(n), 32'd10);
        tick();
        check("t5_ready_drop", 32'(if_b.READY), 32'd0);
        btn = 4'b0001;
        count_bit(1, 6, 12, n);
        check("t5_late_press", 32'(n), 32'd0);
        btn = 4'b0000; repeat (8) tick();

        // 256 ballots wrap the counter.
        do_reset();
        for (int b = 0; b < 256; b++) begin
            ben = 1'b1; tick();
            ben = 1'b0; btn = 4'b0001;
            repeat (9) tick();
            btn = 4'b0000;
            repeat (8) tick();
            if (b == 254) check("t6_count255", 32'(get_cnt(0)), 32'd255);
        end
        check("t6_wrap_a", 32'(get_cnt(0)), 32'd0);
        check("t6_wrap_b", 32'(get_cnt(1)), 32'd0);

        // Reset during CAST drops the vote at once.
        do_reset();
        issue();
        btn = 4'b0001;
        wait_bit(0, 6, 30, n);
        check("t7_in_cast", 32'(n), 32'd7);
        clear_n = 1'b0;
        #1;
        check("t7_vote_drop", 32'(if_a.P1), 32'd0);
        check("t7_count", 32'(get_cnt(0)), 32'd0);
        do_reset();

        // Random buttons, ballots and occasional resets against the model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: btn = 4'b0000;
                    4:          btn = 4'($urandom_range(0, 15));
                    default:    btn = 4'(1 << $urandom_range(0, 3));
                endcase
                hold = $urandom_range(1, 14);
            end
            hold--;
            ben     = ($urandom_range(0, 7) == 0);
            clear_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        clear_n = 1'b1;
        g = get_out(0);
        check("rand_end_onehot", 32'($countones(g[6:3]) <= 1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
